dwt_block_loader: RTL and testbench

DWT_BLOCK_LOADER -- requirements
Module: dwt_block_loader

---
 rtl/dwt_pkg.sv | 20 ++
 rtl/dwt_blk_bank.sv | 37 +++
 rtl/dwt_block_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_dwt_block_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared constants and types for the DWT block front end.
package dwt_pkg;

    localparam int BLK_DIM   = 8;
    localparam int BLK_PIX   = 64;
    localparam int IDX_W     = 6;
    localparam int PIX_W_DEF = 8;
    localparam int CNT_W     = 16;

    localparam logic [IDX_W-1:0] IDX_LAST = 6'd63;

    // One assembled block row at the default pixel width
    typedef logic [BLK_DIM*PIX_W_DEF-1:0] row_t;

    // Bit slot (counted from the LSB end) of raster pixel idx in a flat block; pixel 0 is the MSB lane
    function automatic logic [IDX_W-1:0] pix_slot(input logic [IDX_W-1:0] idx);
        return IDX_LAST - idx;
    endfunction

endpackage

// File: rtl/dwt_blk_bank.sv
// dwt_blk_bank: one 8x8 pixel bank, written a pixel at a time, read as a flat block
// with row 0 / lane 0 in the most significant bits.
module dwt_blk_bank
    import dwt_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [BLK_PIX*PIX_W-1:0] blk_data
);

    logic [BLK_PIX*PIX_W-1:0] data_r;
    logic [IDX_W-1:0]         slot_s;

    assign slot_s = pix_slot(wr_idx);

    // Pixel storage: clear wins over write, which never target the same bank together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
        end else if (clr) begin
            data_r <= '0;
        end else if (wr_en) begin
            data_r[slot_s*PIX_W +: PIX_W] <= wr_data;
        end else begin
            data_r <= data_r;
        end
    end

    assign blk_data = data_r;

endmodule

// File: rtl/dwt_block_loader.sv
// dwt_block_loader: assembles raster pixels into 8x8 blocks for the DWT stage inputs.
// Define DWT_LOADER_DOUBLE_BUF_EN for two ping-pong banks; the default build has one bank.
module dwt_block_loader
    import dwt_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [8*PIX_W-1:0]   row1,
    output logic [8*PIX_W-1:0]   row2,
    output logic [8*PIX_W-1:0]   row3,
    output logic [8*PIX_W-1:0]   row4,
    output logic [8*PIX_W-1:0]   row5,
    output logic [8*PIX_W-1:0]   row6,
    output logic [8*PIX_W-1:0]   row7,
    output logic [8*PIX_W-1:0]   row8,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [CNT_W-1:0]     blk_cnt
);

    localparam int ROW_W  = BLK_DIM * PIX_W;
    localparam int BANK_W = BLK_PIX * PIX_W;

    logic [IDX_W-1:0]  fill_idx_r;
    logic              pix_ready_r;
    logic              blk_valid_r;
    logic [BANK_W-1:0] blk_r;
    logic [CNT_W-1:0]  blk_cnt_r;

    logic              accept_s;
    logic              fill_done_s;
    logic              handoff_s;
    logic              cand_full_s;
    logic              cand_fwd_s;
    logic              pix_ready_n_s;
    logic [BANK_W-1:0] cand_data_s;
    logic [BANK_W-1:0] blk_next_s;

    assign accept_s    = pix_valid && pix_ready_r;
    assign fill_done_s = accept_s && (fill_idx_r == IDX_LAST);
    assign handoff_s   = blk_valid_r && blk_ready;

`ifdef DWT_LOADER_DOUBLE_BUF_EN
    logic [1:0]        full_r;
    logic [1:0]        full_n_s;
    logic [1:0]        wr_s;
    logic [1:0]        clr_s;
    logic              fill_sel_r;
    logic              pres_sel_r;
    logic              fill_sel_n_s;
    logic              pres_sel_n_s;
    logic              other_sel_s;
    logic [BANK_W-1:0] bank_data_s [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dwt_blk_bank #(.PIX_W(PIX_W)) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr_s[b]),
            .wr_en    (wr_s[b]),
            .wr_idx   (fill_idx_r),
            .wr_data  (pix_in),
            .blk_data (bank_data_s[b])
        );
    end

    assign other_sel_s = ~pres_sel_r;

    // Bank flags, pointers and choice of the block to present after this edge
    always_comb begin
        full_n_s     = full_r;
        wr_s         = 2'b00;
        clr_s        = 2'b00;
        cand_full_s  = 1'b0;
        cand_fwd_s   = 1'b0;
        cand_data_s  = bank_data_s[pres_sel_r];
        fill_sel_n_s = fill_sel_r;
        pres_sel_n_s = pres_sel_r;
        if (handoff_s) begin
            full_n_s[pres_sel_r] = 1'b0;
            clr_s[pres_sel_r]    = 1'b1;
            pres_sel_n_s         = other_sel_s;
        end else begin
            pres_sel_n_s = pres_sel_r;
        end
        if (accept_s) begin
            wr_s[fill_sel_r] = 1'b1;
        end else begin
            wr_s = 2'b00;
        end
        if (fill_done_s) begin
            full_n_s[fill_sel_r] = 1'b1;
            fill_sel_n_s         = ~fill_sel_r;
        end else begin
            fill_sel_n_s = fill_sel_r;
        end
        // A bank completing on the handoff edge is forwarded so blk_valid never dips
        if (handoff_s) begin
            cand_data_s = bank_data_s[other_sel_s];
            cand_fwd_s  = fill_done_s && (fill_sel_r == other_sel_s);
            cand_full_s = full_r[other_sel_s] || cand_fwd_s;
        end else begin
            cand_full_s = full_r[pres_sel_r];
        end
        pix_ready_n_s = ~full_n_s[fill_sel_n_s];
    end

    // Bank flag and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r     <= 2'b00;
            fill_sel_r <= 1'b0;
            pres_sel_r <= 1'b0;
        end else begin
            full_r     <= full_n_s;
            fill_sel_r <= fill_sel_n_s;
            pres_sel_r <= pres_sel_n_s;
        end
    end
`else
    logic              full_r;
    logic              full_n_s;
    logic              wr_s;
    logic              clr_s;
    logic [BANK_W-1:0] bank_data_s;

    dwt_blk_bank #(.PIX_W(PIX_W)) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .wr_en    (wr_s),
        .wr_idx   (fill_idx_r),
        .wr_data  (pix_in),
        .blk_data (bank_data_s)
    );

    // Single bank: fill and handoff never coincide because pix_ready is low while full
    always_comb begin
        full_n_s    = full_r;
        wr_s        = accept_s;
        clr_s       = handoff_s;
        cand_fwd_s  = 1'b0;
        cand_full_s = 1'b0;
        cand_data_s = bank_data_s;
        if (handoff_s) begin
            full_n_s    = 1'b0;
            cand_full_s = 1'b0;
        end else if (fill_done_s) begin
            full_n_s    = 1'b1;
            cand_full_s = full_r;
        end else begin
            cand_full_s = full_r;
        end
        pix_ready_n_s = ~full_n_s;
    end

    // Bank flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_n_s;
        end
    end
`endif

    // Next presented block, with the last pixel bypassed when it lands this edge
    always_comb begin
        blk_next_s = cand_data_s;
        if (cand_fwd_s) begin
            blk_next_s[PIX_W-1:0] = pix_in;
        end else begin
            blk_next_s = cand_data_s;
        end
    end

    // Fill index, presentation registers and handoff counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_idx_r  <= '0;
            pix_ready_r <= 1'b0;
            blk_valid_r <= 1'b0;
            blk_r       <= '0;
            blk_cnt_r   <= 16'd0;
        end else begin
            pix_ready_r <= pix_ready_n_s;
            if (accept_s) begin
                fill_idx_r <= fill_idx_r + 6'd1;
            end
            if (handoff_s) begin
                blk_cnt_r <= blk_cnt_r + 16'd1;
            end
            if (!blk_valid_r || handoff_s) begin
                blk_valid_r <= cand_full_s;
                if (cand_full_s) begin
                    blk_r <= blk_next_s;
                end
            end
        end
    end

    assign pix_ready = pix_ready_r;
    assign blk_valid = blk_valid_r;
    assign blk_cnt   = blk_cnt_r;

    assign row1 = blk_r[7*ROW_W +: ROW_W];
    assign row2 = blk_r[6*ROW_W +: ROW_W];
    assign row3 = blk_r[5*ROW_W +: ROW_W];
    assign row4 = blk_r[4*ROW_W +: ROW_W];
    assign row5 = blk_r[3*ROW_W +: ROW_W];
    assign row6 = blk_r[2*ROW_W +: ROW_W];
    assign row7 = blk_r[1*ROW_W +: ROW_W];
    assign row8 = blk_r[0*ROW_W +: ROW_W];

endmodule

// File: tb/tb_dwt_block_loader.sv
// Scoreboard bench for dwt_block_loader; expectations follow DWT_LOADER_DOUBLE_BUF_EN.
module tb_dwt_block_loader;
    import dwt_pkg::*;

    typedef logic [511:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_in = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    row_t        row1, row2, row3, row4, row5, row6, row7, row8;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    logic [15:0] blk_cnt;

    blk_t        sb_q [$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [7:0]  pat [8];

    always #5 clk = ~clk;

    dwt_block_loader #(.PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .row1      (row1),
        .row2      (row2),
        .row3      (row3),
        .row4      (row4),
        .row5      (row5),
        .row6      (row6),
        .row7      (row7),
        .row8      (row8),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_cnt   (blk_cnt)
    );

    function automatic blk_t ramp_blk(input logic [7:0] base);
        blk_t b;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            b[(63-i)*8 +: 8] = base + 8'(i);
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_pix(input logic [7:0] d);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        pix_in = d;
        pix_valid = 1'b1;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL pix_accept_timeout: pixel %0h not accepted", d);
        end
    endtask

    task automatic send_blk(input logic [7:0] base);
        sb_q.push_back(ramp_blk(base));
        for (int i = 0; i < 64; i++) begin
            send_pix(base + 8'(i));
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d blocks still expected", sb_q.size());
        end
    endtask

    // Monitor: every handoff pops the oldest expected block
    initial begin
        blk_t exp_b;
        forever begin
            @(negedge clk);
            if (rst_n && blk_valid && blk_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %0h expected none", {row1, row2, row3, row4, row5, row6, row7, row8});
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("block_rows", {row1, row2, row3, row4, row5, row6, row7, row8}, exp_b);
                end
                chk("blk_cnt_at_handoff", blk_cnt, exp_cnt);
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 8'h20; pat[1] = 8'h30; pat[2] = 8'h2C; pat[3] = 8'h62;
        pat[4] = 8'h02; pat[5] = 8'h62; pat[6] = 8'hC6; pat[7] = 8'h16;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rows", {row1, row2, row3, row4, row5, row6, row7, row8}, 512'd0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_blk_cnt", blk_cnt, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pix_ready_after_rst", pix_ready, 1'b1);

        // Ramp 0x00..0x3F with the sink always ready
        blk_ready = 1'b1;
        send_blk(8'h00);
        pix_valid = 1'b0;
        chk("valid_latency_edge0", blk_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("valid_latency_edge1", blk_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("blk_cnt_first", blk_cnt, 16'd1);
        chk("valid_after_handoff", blk_valid, 1'b0);
        chk("row1_hold", row1, 64'h0001020304050607);
        chk("row8_hold", row8, 64'h38393A3B3C3D3E3F);

        // Repeated row pattern
        sb_q.push_back({8{64'h20302C620262C616}});
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                send_pix(pat[c]);
            end
        end
        pix_valid = 1'b0;
        wait_drain();
        chk("blk_cnt_pattern", blk_cnt, 16'd2);

        // Backpressure: sink stalled, source keeps offering
        blk_ready = 1'b0;
        send_blk(8'h40);
`ifdef DWT_LOADER_DOUBLE_BUF_EN
        chk("pix_ready_after_64", pix_ready, 1'b1);
        send_blk(8'hC0);
`endif
        chk("pix_ready_full", pix_ready, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("pix_ready_stall", pix_ready, 1'b0);
        chk("valid_stall", blk_valid, 1'b1);
        chk("row1_stall", row1, 64'h4041424344454647);
        chk("row8_stall", row8, 64'h78797A7B7C7D7E7F);
        pix_valid = 1'b0;
        blk_ready = 1'b1;
        wait_drain();
        chk("pix_ready_after_drain", pix_ready, 1'b1);

`ifdef DWT_LOADER_DOUBLE_BUF_EN
        // Fill completes on the handoff edge
        blk_ready = 1'b0;
        send_blk(8'h10);
        sb_q.push_back(ramp_blk(8'h50));
        for (int i = 0; i < 63; i++) begin
            send_pix(8'h50 + 8'(i));
        end
        blk_ready = 1'b1;
        send_pix(8'h8F);
        pix_valid = 1'b0;
        chk("same_edge_valid", blk_valid, 1'b1);
        chk("same_edge_cnt", blk_cnt, 16'd5);
        wait_drain();
        chk("same_edge_cnt_after", blk_cnt, 16'd6);
`endif

        // Reset in the middle of a fill
        blk_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_pix(8'h11 + 8'(i));
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rows", {row1, row2, row3, row4, row5, row6, row7, row8}, 512'd0);
        chk("midrst_blk_valid", blk_valid, 1'b0);
        chk("midrst_pix_ready", pix_ready, 1'b0);
        chk("midrst_blk_cnt", blk_cnt, 16'h0000);
        exp_cnt = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_blk(8'h80);
        pix_valid = 1'b0;
        wait_drain();
        chk("post_rst_cnt", blk_cnt, 16'd1);
        chk("post_rst_row1", row1, 64'h8081828384858687);

        // Counter wrap
        force dut.blk_cnt_r = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_r;
        @(posedge clk);
        #1;
        chk("cnt_forced", blk_cnt, 16'hFFFF);
        send_blk(8'h20);
        pix_valid = 1'b0;
        wait_drain();
        chk("cnt_wrap", blk_cnt, 16'h0000);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
